data_ram_master: RTL and testbench

- Initiator side of the MEM-stage data RAM interface.
- Accepts one load/store request at a time from the MEM stage and drives ce/we/addr/sel/data plus the access-latency count to the data RAM.
- Interprets the RAM's registered hit/data responses, including the cache-refill cycle.
- Holds the pipeline via stallreq_o until a single-cycle ack_o returns the load data or confirms the store.

---
 rtl/data_ram_master_pkg.sv | 31 +++
 rtl/data_ram_master_if.sv | 27 ++
 rtl/data_ram_master_lat_counter.sv | 29 ++
 rtl/data_ram_master.sv | 124 ++++++++++++
 tb/tb_data_ram_master.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/data_ram_master_pkg.sv
// Shared types and constants for the MEM-stage data RAM initiator.
package data_ram_master_pkg;

  localparam int unsigned LATENCY_DEF = 200;
  localparam int unsigned CNT_W_DEF   = 32;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned SEL_W       = 4;

  localparam logic ChipEnable   = 1'b1;
  localparam logic ChipDisable  = 1'b0;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic [DATA_W-1:0] ZeroWord = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_e;

  // Request fields captured from the MEM stage when an access is accepted.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/data_ram_master_if.sv
// Data RAM bus: initiator drives request fields, RAM returns registered hit/data.
interface data_ram_master_if
  import data_ram_master_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) ();

  logic              ram_ce_o;
  logic              ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [SEL_W-1:0]  ram_sel_o;
  logic [DATA_W-1:0] ram_data_o;
  logic [CNT_W-1:0]  ram_cnt_o;
  logic              ram_hit_i;
  logic [DATA_W-1:0] ram_data_i;

  modport master (
    output ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o, ram_cnt_o,
    input  ram_hit_i, ram_data_i
  );

  modport slave (
    input  ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o, ram_cnt_o,
    output ram_hit_i, ram_data_i
  );

endinterface

// File: rtl/data_ram_master_lat_counter.sv
// Saturating access-latency counter with clear; also keeps last cycle's value.
module data_ram_master_lat_counter #(
  parameter int unsigned LATENCY = 200,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] prev_cnt_o
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(LATENCY);

  // Count up while enabled, stopping at LATENCY; prev tracks the value just driven.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_o    <= '0;
      prev_cnt_o <= '0;
    end else if (en) begin
      prev_cnt_o <= count_o;
      if (count_o < CntMax) begin
        count_o <= count_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/data_ram_master.sv
// MEM-stage data RAM initiator: one load/store at a time, stalls until ack.
module data_ram_master
  import data_ram_master_pkg::*;
#(
  parameter int unsigned LATENCY = LATENCY_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [SEL_W-1:0]  sel_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              stallreq_o,
  output logic              ack_o,
  output logic [DATA_W-1:0] rdata_o,
  data_ram_master_if.master ram
);

  localparam logic [CNT_W-1:0] CntLat = CNT_W'(LATENCY);

  state_e            state_q, state_d;
  mem_req_t          req_q;
  logic              first_q, first_d;
  logic              fill_q, fill_d;
  logic [DATA_W-1:0] rdata_q;
  logic              latch, capture, cnt_clr, cnt_en;
  logic [CNT_W-1:0]  count, prev_cnt;
  logic              busy;

  data_ram_master_lat_counter #(
    .LATENCY (LATENCY),
    .CNT_W   (CNT_W)
  ) u_lat_counter (
    .clk        (clk),
    .rst        (rst),
    .clr        (cnt_clr),
    .en         (cnt_en),
    .count_o    (count),
    .prev_cnt_o (prev_cnt)
  );

  // State, response-tracking flags, latched request and load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      first_q <= 1'b1;
      fill_q  <= 1'b0;
      req_q   <= '0;
      rdata_q <= ZeroWord;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      fill_q  <= fill_d;
      if (latch) begin
        req_q <= '{we: we_i, addr: addr_i, sel: sel_i, wdata: wdata_i};
      end
      if (capture) begin
        rdata_q <= ram.ram_data_i;
      end
    end
  end

  // Next state: the first RD sample is stale, and the refill-cycle hit carries stale data.
  always_comb begin
    state_d = state_q;
    first_d = first_q;
    fill_d  = fill_q;
    latch   = 1'b0;
    capture = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          latch   = 1'b1;
          cnt_clr = 1'b1;
          first_d = 1'b1;
          fill_d  = 1'b0;
          state_d = we_i ? WR : RD;
        end
      end
      RD: begin
        cnt_en = 1'b1;
        if (first_q) begin
          first_d = 1'b0;
        end else if (ram.ram_hit_i && (prev_cnt == CntLat) && !fill_q) begin
          fill_d = 1'b1;
        end else if (ram.ram_hit_i) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      WR: begin
        cnt_en = 1'b1;
        if (count == CntLat) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the current state; stall in IDLE follows req_i directly.
  always_comb begin
    busy           = (state_q == RD) || (state_q == WR);
    stallreq_o     = (state_q == IDLE) ? req_i : busy;
    ack_o          = (state_q == RESP);
    rdata_o        = rdata_q;
    ram.ram_ce_o   = busy ? ChipEnable : ChipDisable;
    ram.ram_we_o   = (state_q == WR) ? WriteEnable : WriteDisable;
    ram.ram_addr_o = req_q.addr;
    ram.ram_sel_o  = req_q.sel;
    ram.ram_data_o = req_q.wdata;
    ram.ram_cnt_o  = busy ? count : '0;
  end

endmodule

// File: tb/tb_data_ram_master.sv
// Directed bench for data_ram_master with a registered data-RAM model.
module tb_data_ram_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [3:0]  sel_i;
  logic [31:0] wdata_i;
  logic        stallreq_o;
  logic        ack_o;
  logic [31:0] rdata_o;

  int errors = 0;
  int checks = 0;

  data_ram_master_if #(.CNT_W(32)) ram_bus ();

  data_ram_master #(.LATENCY(200), .CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .sel_i      (sel_i),
    .wdata_i    (wdata_i),
    .stallreq_o (stallreq_o),
    .ack_o      (ack_o),
    .rdata_o    (rdata_o),
    .ram        (ram_bus)
  );

  always #5 clk = ~clk;

  // RAM model: words 0..127 start cached; others refill when cnt reaches 200.
  bit [31:0] mem_q [256];
  bit        wr_q  [256];
  bit        fl_q  [256];
  bit        hit_q;
  bit [31:0] rd_q;
  logic [7:0] ridx;

  assign ridx              = ram_bus.ram_addr_o[9:2];
  assign ram_bus.ram_hit_i  = hit_q;
  assign ram_bus.ram_data_i = rd_q;

  function automatic bit [31:0] default_word(input logic [7:0] idx);
    return 32'hC0DE_0000 | {24'h0, idx};
  endfunction

  function automatic bit [31:0] merge(input bit [31:0] old, input logic [31:0] nw,
                                      input logic [3:0] sel);
    bit [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (ram_bus.ram_ce_o) begin
      if (ram_bus.ram_we_o) begin
        if (ram_bus.ram_cnt_o == 32'd200) begin
          mem_q[ridx] <= merge(wr_q[ridx] ? mem_q[ridx] : default_word(ridx),
                               ram_bus.ram_data_o, ram_bus.ram_sel_o);
          wr_q[ridx]  <= 1'b1;
        end
        hit_q <= 1'b0;
      end else if (ridx < 8'd128 || fl_q[ridx] || wr_q[ridx]) begin
        hit_q <= 1'b1;
        rd_q  <= wr_q[ridx] ? mem_q[ridx] : default_word(ridx);
      end else if (ram_bus.ram_cnt_o == 32'd200) begin
        fl_q[ridx] <= 1'b1;
        hit_q      <= 1'b1;
        rd_q       <= 32'hBAD0_BAD0;
      end else begin
        hit_q <= 1'b0;
        rd_q  <= 32'hBAD0_BAD0;
      end
    end
  end

  // Per-access observations filled in by run_access.
  int          ra_ack_cyc;
  int          ra_ack_cnt;
  int          ra_stall_bad;
  int          ra_we_cyc;
  int          ra_cnt200;
  int          ra_cnt_max;
  int          ra_wrap;
  logic [31:0] ra_rdata;

  task automatic observe(input int c);
    if (ack_o) begin
      ra_ack_cnt++;
      if (ra_ack_cyc < 0) begin
        ra_ack_cyc = c;
        ra_rdata   = rdata_o;
      end
    end
    if ((ra_ack_cyc < 0) ? !stallreq_o : stallreq_o) ra_stall_bad++;
    if (ram_bus.ram_we_o) ra_we_cyc++;
    if (ram_bus.ram_ce_o) begin
      if (ram_bus.ram_cnt_o == 32'd200) ra_cnt200++;
      if (int'(ram_bus.ram_cnt_o) < ra_cnt_max) ra_wrap++;
      if (int'(ram_bus.ram_cnt_o) > ra_cnt_max) ra_cnt_max = int'(ram_bus.ram_cnt_o);
    end
  endtask

  // One access, req_i pulsed in cycle 0 then inputs scrambled; runs until ack or budget.
  task automatic run_access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                            input logic [31:0] wdata);
    ra_ack_cyc = -1; ra_ack_cnt = 0; ra_stall_bad = 0; ra_we_cyc = 0;
    ra_cnt200 = 0; ra_cnt_max = 0; ra_wrap = 0; ra_rdata = 32'h0;
    @(negedge clk);
    req_i = 1'b1; we_i = we; addr_i = addr; sel_i = sel; wdata_i = wdata;
    #1;
    observe(0);
    for (int c = 1; c < 1000 && ra_ack_cyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_i = 1'b0; we_i = ~we; addr_i = 32'h0000_03FC; sel_i = 4'h1; wdata_i = 32'h1234_5678;
      end
      #1;
      observe(c);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; sel_i = '0; wdata_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stallreq_o); end
    checks++; if (ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", ack_o); end
    checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata_o); end
    checks++; if ({ram_bus.ram_ce_o, ram_bus.ram_we_o} !== 2'b00) begin errors++; $display("FAIL reset_ce_we got=%b exp=00", {ram_bus.ram_ce_o, ram_bus.ram_we_o}); end
    checks++; if (ram_bus.ram_cnt_o !== 32'h0 || ram_bus.ram_addr_o !== 32'h0) begin errors++; $display("FAIL reset_cnt_addr got=%h/%h exp=0/0", ram_bus.ram_cnt_o, ram_bus.ram_addr_o); end
  endtask

  task automatic test_cached_load;
    run_access(1'b0, 32'h0000_0010, 4'hF, 32'h0);
    checks++; if (ra_ack_cyc !== 3) begin errors++; $display("FAIL cached_ack_cycle got=%0d exp=3", ra_ack_cyc); end
    checks++; if (ra_rdata !== 32'hC0DE_0004) begin errors++; $display("FAIL cached_rdata got=%h exp=c0de0004", ra_rdata); end
    checks++; if (ra_stall_bad !== 0) begin errors++; $display("FAIL cached_stall bad_cycles=%0d exp=0", ra_stall_bad); end
    @(negedge clk);
    checks++; if (ack_o !== 1'b0 || rdata_o !== 32'hC0DE_0004) begin errors++; $display("FAIL cached_hold ack=%b rdata=%h exp=0/c0de0004", ack_o, rdata_o); end
  endtask

  // Runs right after a cached load, so the RAM's hit flag is still 1 in the first RD cycle.
  task automatic test_miss_load;
    run_access(1'b0, 32'h0000_0300, 4'hF, 32'h0);
    checks++; if (ra_ack_cyc !== 204) begin errors++; $display("FAIL miss_ack_cycle got=%0d exp=204", ra_ack_cyc); end
    checks++; if (ra_ack_cnt !== 1) begin errors++; $display("FAIL miss_ack_count got=%0d exp=1", ra_ack_cnt); end
    checks++; if (ra_rdata !== 32'hC0DE_00C0) begin errors++; $display("FAIL miss_rdata got=%h exp=c0de00c0", ra_rdata); end
    checks++; if (ra_cnt_max !== 200 || ra_wrap !== 0) begin errors++; $display("FAIL miss_cnt_sat max=%0d wraps=%0d exp=200/0", ra_cnt_max, ra_wrap); end
    checks++; if (ra_stall_bad !== 0) begin errors++; $display("FAIL miss_stall bad_cycles=%0d exp=0", ra_stall_bad); end
  endtask

  task automatic test_store;
    run_access(1'b1, 32'h0000_0040, 4'hF, 32'hDEAD_BEEF);
    checks++; if (ra_ack_cyc !== 202) begin errors++; $display("FAIL store_ack_cycle got=%0d exp=202", ra_ack_cyc); end
    checks++; if (ra_we_cyc !== 201) begin errors++; $display("FAIL store_we_cycles got=%0d exp=201", ra_we_cyc); end
    checks++; if (ra_cnt200 !== 1) begin errors++; $display("FAIL store_cnt200 got=%0d exp=1", ra_cnt200); end
    run_access(1'b0, 32'h0000_0040, 4'hF, 32'h0);
    checks++; if (ra_ack_cyc !== 3) begin errors++; $display("FAIL store_readback_cycle got=%0d exp=3", ra_ack_cyc); end
    checks++; if (ra_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_readback got=%h exp=deadbeef", ra_rdata); end
  endtask

  task automatic test_reset_mid;
    bit found;
    found = 1'b0;
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_0380; sel_i = 4'hF;
    for (int c = 1; c < 400 && !found; c++) begin
      @(negedge clk);
      req_i = 1'b0;
      #1;
      if (ram_bus.ram_ce_o && ram_bus.ram_cnt_o == 32'd50) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL rstmid_reach_cnt50 got=not_seen exp=seen"); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({ram_bus.ram_ce_o, ram_bus.ram_we_o, stallreq_o, ack_o} !== 4'b0000) begin errors++; $display("FAIL rstmid_ctrl got=%b exp=0000", {ram_bus.ram_ce_o, ram_bus.ram_we_o, stallreq_o, ack_o}); end
    checks++; if (rdata_o !== 32'h0 || ram_bus.ram_cnt_o !== 32'h0 || ram_bus.ram_addr_o !== 32'h0) begin errors++; $display("FAIL rstmid_data got=%h/%h/%h exp=0/0/0", rdata_o, ram_bus.ram_cnt_o, ram_bus.ram_addr_o); end
    run_access(1'b0, 32'h0000_0020, 4'hF, 32'h0);
    checks++; if (ra_ack_cyc !== 3 || ra_rdata !== 32'hC0DE_0008) begin errors++; $display("FAIL rstmid_recover cyc=%0d rdata=%h exp=3/c0de0008", ra_ack_cyc, ra_rdata); end
  endtask

  task automatic test_back_to_back;
    logic [12:0] ack_v, ce_v, stall_v;
    ack_v = '0; ce_v = '0; stall_v = '0;
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_0010; sel_i = 4'hF;
    #1;
    ack_v[0] = ack_o; ce_v[0] = ram_bus.ram_ce_o; stall_v[0] = stallreq_o;
    for (int c = 1; c < 13; c++) begin
      @(negedge clk);
      #1;
      ack_v[c] = ack_o; ce_v[c] = ram_bus.ram_ce_o; stall_v[c] = stallreq_o;
      if (c == 7) req_i = 1'b0;
    end
    checks++; if (ack_v !== 13'b0_0000_1000_1000) begin errors++; $display("FAIL b2b_ack_pattern got=%b exp=0000010001000", ack_v); end
    checks++; if (ce_v !== 13'b0_0000_0110_0110) begin errors++; $display("FAIL b2b_ce_pattern got=%b exp=0000001100110", ce_v); end
    checks++; if (stall_v[4] !== 1'b1 || stall_v[3] !== 1'b0 || stall_v[7] !== 1'b0) begin errors++; $display("FAIL b2b_stall c3=%b c4=%b c7=%b exp=0/1/0", stall_v[3], stall_v[4], stall_v[7]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout reached exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_cached_load();
    test_miss_load();
    test_store();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
